// File: rtl/display_scanout_if.sv
// Framebuffer read port, panel outputs and render handshake between the
// display scanout engine and its neighbours.
interface display_scanout_if #(
  parameter int XW = 9,
  parameter int YW = 8
);
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [15:0]   pixel_in;
  logic [4:0]    rgb_r;
  logic [5:0]    rgb_g;
  logic [4:0]    rgb_b;
  logic          de;
  logic          hsync_n;
  logic          vsync_n;
  logic          frame_start;
  logic          frame_done;
  logic          render_busy;
  logic [7:0]    skip_count;

  modport master (
    output x_out, y_out, rgb_r, rgb_g, rgb_b, de, hsync_n, vsync_n,
           frame_start, render_busy, skip_count,
    input  pixel_in, frame_done
  );

  modport slave (
    input  x_out, y_out, rgb_r, rgb_g, rgb_b, de, hsync_n, vsync_n,
           frame_start, render_busy, skip_count,
    output pixel_in, frame_done
  );
endinterface

// File: rtl/display_scanout.sv
// Raster timing generator: scans the framebuffer, aligns returned pixels with
// de/sync for the panel, and launches rendering once per frame.
module display_scanout #(
  parameter int H_ACTIVE   = 320,
  parameter int H_FP       = 8,
  parameter int H_SYNC     = 32,
  parameter int H_BP       = 40,
  parameter int V_ACTIVE   = 240,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 15,
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  display_scanout_if.master bus
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int XW       = $clog2(H_ACTIVE);
  localparam int YW       = $clog2(V_ACTIVE);
  localparam int HS_BEGIN = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_BEGIN + H_SYNC;
  localparam int VS_BEGIN = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_BEGIN + V_SYNC;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          active;
  logic          hs_raw;
  logic          vs_raw;
  logic          launch;

  // {de, hsync, vsync}, active-high, one entry per clock of read latency
  logic [RD_LATENCY-1:0][2:0] sync_dly;
  logic [RD_LATENCY-1:0][2:0] dly_next;
  logic [2:0]                 dly_tail;

  logic       busy;
  logic [7:0] skips;

  always_comb begin
    h_last = (h_cnt == HW'(H_TOTAL - 1));
    v_last = (v_cnt == VW'(V_TOTAL - 1));
    active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    hs_raw = (h_cnt >= HW'(HS_BEGIN)) && (h_cnt < HW'(HS_END));
    vs_raw = (v_cnt >= VW'(VS_BEGIN)) && (v_cnt < VW'(VS_END));
    launch = (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.x_out = active ? h_cnt[XW-1:0] : '0;
    bus.y_out = active ? v_cnt[YW-1:0] : '0;
  end

  if (RD_LATENCY > 1) begin : g_deep
    always_comb dly_next = {sync_dly[RD_LATENCY-2:0], {active, hs_raw, vs_raw}};
  end else begin : g_shallow
    always_comb dly_next = {active, hs_raw, vs_raw};
  end

  always_comb dly_tail = sync_dly[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_dly <= '0;
    end else begin
      sync_dly <= dly_next;
    end
  end

  // Output register: pixel data arrives exactly when its timing reaches the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rgb_r   <= '0;
      bus.rgb_g   <= '0;
      bus.rgb_b   <= '0;
      bus.de      <= 1'b0;
      bus.hsync_n <= 1'b1;
      bus.vsync_n <= 1'b1;
    end else begin
      bus.rgb_r   <= dly_tail[2] ? bus.pixel_in[15:11] : '0;
      bus.rgb_g   <= dly_tail[2] ? bus.pixel_in[10:5]  : '0;
      bus.rgb_b   <= dly_tail[2] ? bus.pixel_in[4:0]   : '0;
      bus.de      <= dly_tail[2];
      bus.hsync_n <= ~dly_tail[1];
      bus.vsync_n <= ~dly_tail[0];
    end
  end

  // A done coinciding with a launch closes the previous frame, so the launch goes ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.frame_start <= 1'b0;
      busy            <= 1'b0;
      skips           <= '0;
    end else begin
      bus.frame_start <= 1'b0;
      if (launch) begin
        busy <= 1'b1;
        if (!busy || bus.frame_done) begin
          bus.frame_start <= 1'b1;
        end else if (skips != '1) begin
          skips <= skips + 1'b1;
        end
      end else if (bus.frame_done) begin
        busy <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.render_busy = busy;
    bus.skip_count  = skips;
  end
endmodule

// File: tb/tb_display_scanout.sv
// Directed bench for display_scanout on a reduced raster (24x13 clocks/lines)
// so that several frames, overruns and a mid-frame reset fit in a short run.
module tb_display_scanout;
  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 3;
  localparam int VA  = 8;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;   // 24
  localparam int VT  = VA + VFP + VS + VBP;   // 13, frame = 312 clocks

  logic clk;
  logic rst;

  display_scanout_if #(.XW(4), .YW(3)) bus ();

  display_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .RD_LATENCY(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;
  int t;
  int since;
  int prev_x;
  int prev_y;
  logic       fs_m;
  logic       busy_m;
  logic [7:0] skip_m;
  int cnt_de, cnt_hs, cnt_vs, cnt_fs, cnt_busy;

  function automatic logic [15:0] pix(input int x, input int y);
    return 16'(x * 2113 + y * 97 + 'h0841);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, expv);
  endtask

  task automatic model_reset();
    t      = 0;
    fs_m   = 1'b0;
    busy_m = 1'b0;
    skip_m = '0;
    since  = 1000000;
    prev_x = 0;
    prev_y = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_x", 32'(bus.x_out), 0);
    chk("rst_y", 32'(bus.y_out), 0);
    chk("rst_rgb", 32'({bus.rgb_r, bus.rgb_g, bus.rgb_b}), 0);
    chk("rst_de", 32'(bus.de), 0);
    chk("rst_hsync_n", 32'(bus.hsync_n), 1);
    chk("rst_vsync_n", 32'(bus.vsync_n), 1);
    chk("rst_frame_start", 32'(bus.frame_start), 0);
    chk("rst_busy", 32'(bus.render_busy), 0);
    chk("rst_skip", 32'(bus.skip_count), 0);
  endtask

  // dly >= 0: renderer answers dly clocks after frame_start; -1: done held 0; -2: done held 1
  task automatic run(input int n, input int dly);
    int hh, vv, ph, pv;
    logic fd, launch, e_de, e_hs_n, e_vs_n;
    logic [15:0] e_rgb;
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0; cnt_busy = 0;
    for (int i = 0; i < n; i++) begin
      hh = t % HT;
      vv = (t / HT) % VT;
      chk("x_out", 32'(bus.x_out), (hh < HA && vv < VA) ? hh : 0);
      chk("y_out", 32'(bus.y_out), (hh < HA && vv < VA) ? vv : 0);
      e_de = 1'b0; e_hs_n = 1'b1; e_vs_n = 1'b1; e_rgb = '0;
      if (t >= 2) begin
        ph     = (t - 2) % HT;
        pv     = ((t - 2) / HT) % VT;
        e_de   = (ph < HA) && (pv < VA);
        e_hs_n = !((ph >= HA + HFP) && (ph < HA + HFP + HS));
        e_vs_n = !((pv >= VA + VFP) && (pv < VA + VFP + VS));
        e_rgb  = e_de ? pix(ph, pv) : 16'h0000;
      end
      chk("de", 32'(bus.de), 32'(e_de));
      chk("hsync_n", 32'(bus.hsync_n), 32'(e_hs_n));
      chk("vsync_n", 32'(bus.vsync_n), 32'(e_vs_n));
      chk("rgb", 32'({bus.rgb_r, bus.rgb_g, bus.rgb_b}), 32'(e_rgb));
      chk("frame_start", 32'(bus.frame_start), 32'(fs_m));
      chk("render_busy", 32'(bus.render_busy), 32'(busy_m));
      chk("skip_count", 32'(bus.skip_count), 32'(skip_m));
      cnt_de   += int'(bus.de);
      cnt_hs   += int'(!bus.hsync_n);
      cnt_vs   += int'(!bus.vsync_n);
      cnt_fs   += int'(bus.frame_start);
      cnt_busy += int'(bus.render_busy);

      if (bus.frame_start) since = 0;
      if (dly == -2) fd = 1'b1;
      else fd = (dly >= 0) && (since == dly);
      if (since < 1000000) since++;
      bus.frame_done = fd;
      bus.pixel_in   = pix(prev_x, prev_y);
      prev_x = int'(bus.x_out);
      prev_y = int'(bus.y_out);

      launch = (hh == 0) && (vv == VA);
      if (launch) begin
        fs_m = !busy_m || fd;
        if (busy_m && !fd && skip_m != 8'd255) skip_m++;
        busy_m = 1'b1;
      end else begin
        fs_m = 1'b0;
        if (fd) busy_m = 1'b0;
      end
      t++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.frame_done = 1'b0;
    bus.pixel_in   = 16'hFFFF;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    // normal frames, renderer done 20 clocks after each launch
    run(624, 20);
    run(312, 20);
    chk("frame_de_count", 32'(cnt_de), 128);
    chk("frame_hsync_count", 32'(cnt_hs), 39);
    chk("frame_vsync_count", 32'(cnt_vs), 48);
    chk("frame_start_count", 32'(cnt_fs), 1);
    chk("frame_busy_count", 32'(cnt_busy), 21);

    // three launches with no done: one pulse then two skips
    run(936, -1);
    chk("overrun_fs_count", 32'(cnt_fs), 1);
    chk("overrun_skip", 32'(bus.skip_count), 2);
    chk("overrun_busy", 32'(bus.render_busy), 1);

    // done arriving in the launch cycle itself
    run(192, -1);
    run(1, -2);
    chk("done_at_launch_fs", 32'(bus.frame_start), 1);
    chk("done_at_launch_busy", 32'(bus.render_busy), 1);
    chk("done_at_launch_skip", 32'(bus.skip_count), 2);

    // reset mid-line at h=10, v=4
    run(225, 5);
    chk("pre_reset_x", 32'(bus.x_out), 10);
    chk("pre_reset_y", 32'(bus.y_out), 4);
    rst            = 1'b1;
    bus.frame_done = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    model_reset();
    run(250, 20);
    chk("post_reset_fs_count", 32'(cnt_fs), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
